// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - two-phase instruction fetch sequencer with optional return stack
//
// Purpose: alternates fetch and execute phases over a combinational program
// memory. The fetch edge latches the opcode/operand byte and advances pc. The
// execute edge applies one of ret > call > load_pc > inc_pc, where the jump
// target is {operand, rom_data}.
//
// Optional feature macro: RETURN_STACK_EN
//   defined   - return stack with push/pop plus sticky overflow/underflow flags
//   undefined - no stack storage; call acts as load_pc; ret is a no-op that
//               still outranks the lower-priority actions; sp and flags read 0
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   stall      in   freeze every state element this cycle
//   inc_pc     in   execute: skip operand byte
//   load_pc    in   execute: jump to target
//   call       in   execute: push return address, jump to target
//   ret        in   execute: pop return address
//   rom_data   in   byte at address pc
//   pc         out  program counter
//   phase      out  0 = fetch, 1 = execute
//   instr      out  latched opcode (upper bits of fetched byte)
//   operand    out  latched operand (lower bits of fetched byte)
//   sp         out  return-stack occupancy
//   stack_ovf  out  sticky call-on-full flag
//   stack_unf  out  sticky ret-on-empty flag

module fetch_sequencer #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 8,
  parameter int OPC_W       = 4,
  parameter int STACK_DEPTH = 4,
  localparam int OPW        = DATA_W - OPC_W,
  localparam int SP_W       = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              inc_pc,
  input  logic              load_pc,
  input  logic              call,
  input  logic              ret,
  input  logic [DATA_W-1:0] rom_data,
  output logic [ADDR_W-1:0] pc,
  output logic              phase,
  output logic [OPC_W-1:0]  instr,
  output logic [OPW-1:0]    operand,
  output logic [SP_W-1:0]   sp,
  output logic              stack_ovf,
  output logic              stack_unf
);

  // The jump target concatenates the operand nibble with a full byte, so the
  // address width is tied to the data and opcode widths.
  generate
    if (ADDR_W != 2 * DATA_W - OPC_W) begin : g_bad_addr_w
      $error("fetch_sequencer: ADDR_W must equal 2*DATA_W - OPC_W");
    end
    if (STACK_DEPTH < 1) begin : g_bad_depth
      $error("fetch_sequencer: STACK_DEPTH must be at least 1");
    end
  endgenerate

  logic              phase_q, phase_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [OPC_W-1:0]  instr_q, instr_d;
  logic [OPW-1:0]    operand_q, operand_d;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] target;

  assign pc_inc = pc_q + ADDR_W'(1);
  assign target = {operand_q, rom_data};

`ifdef RETURN_STACK_EN
  logic [SP_W-1:0]   sp_q, sp_d, sp_dec;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
  logic [ADDR_W-1:0] stack_top;
  logic              push;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  assign sp_dec = sp_q - SP_W'(1);

  // Entry below the current occupancy; only consumed when sp_q is non-zero.
  always_comb begin
    stack_top = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (sp_dec == SP_W'(i)) stack_top = stack_q[i];
    end
  end
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q   <= 1'b0;
      pc_q      <= '0;
      instr_q   <= '0;
      operand_q <= '0;
`ifdef RETURN_STACK_EN
      sp_q      <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
`endif
    end else begin
      phase_q   <= phase_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      operand_q <= operand_d;
`ifdef RETURN_STACK_EN
      sp_q      <= sp_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        if (push && sp_q == SP_W'(i)) stack_q[i] <= pc_inc;
      end
`endif
    end
  end

  // Next-state logic. Everything defaults to hold, which is also the stall
  // behaviour: a stalled execute edge simply re-evaluates its inputs later.
  always_comb begin
    phase_d   = phase_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    operand_d = operand_q;
`ifdef RETURN_STACK_EN
    sp_d      = sp_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    push      = 1'b0;
`endif
    if (!stall) begin
      phase_d = ~phase_q;
      if (!phase_q) begin
        instr_d   = rom_data[DATA_W-1:OPW];
        operand_d = rom_data[OPW-1:0];
        pc_d      = pc_inc;
      end else if (ret) begin
`ifdef RETURN_STACK_EN
        if (sp_q != '0) begin
          pc_d = stack_top;
          sp_d = sp_dec;
        end else begin
          unf_d = 1'b1;
        end
`endif
      end else if (call) begin
        pc_d = target;
`ifdef RETURN_STACK_EN
        if (sp_q < SP_W'(STACK_DEPTH)) begin
          push = 1'b1;
          sp_d = sp_q + SP_W'(1);
        end else begin
          ovf_d = 1'b1;
        end
`endif
      end else if (load_pc) begin
        pc_d = target;
      end else if (inc_pc) begin
        pc_d = pc_inc;
      end
    end
  end

  // Outputs
  always_comb begin
    pc      = pc_q;
    phase   = phase_q;
    instr   = instr_q;
    operand = operand_q;
`ifdef RETURN_STACK_EN
    sp        = sp_q;
    stack_ovf = ovf_q;
    stack_unf = unf_q;
`else
    sp        = '0;
    stack_ovf = 1'b0;
    stack_unf = 1'b0;
`endif
  end

endmodule
